// File: rtl/cache_refill_unit_pkg.sv
// Shared types and constants for the cache refill unit: FSM state encoding,
// beats per line, line offset width and the bus address line-align helper.
package cache_pkg;

    localparam int LINE_BITS   = 128;
    localparam int BEAT_BITS   = 32;
    localparam int BEATS       = LINE_BITS / BEAT_BITS;
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_ADDR,
        ST_WB_DATA,
        ST_WB_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_COMMIT
    } state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_refill_unit_beat_buf.sv
// Four-slot refill assembly register: beats land lowest slot first, and full
// flags the push that completes the line.
module refill_beat_buf
    import cache_pkg::*;
#(
    parameter int BEAT_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [BEAT_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] line_out,
    output logic                  full
);
    localparam int CNT_W = $clog2(BEATS);

    logic [CNT_W-1:0]                 beat_cnt_q;
    logic [BEATS-1:0][BEAT_WIDTH-1:0] slot_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q <= '0;
            slot_q     <= '0;
        end else if (clear) begin
            beat_cnt_q <= '0;
        end else if (push) begin
            slot_q[beat_cnt_q] <= data_in;
            beat_cnt_q         <= beat_cnt_q + CNT_W'(1);
        end
    end

    assign line_out = slot_q;
    assign full     = push && (beat_cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/cache_refill_unit.sv
// Miss line-transfer engine: optional victim writeback, 4-beat refill, one-cycle
// commit to the data array. Define CACHE_REFILL_ERR_CHECK_EN for the r_last check.
module cache_refill_unit
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int BEAT_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wb,
    input  logic [ADDR_WIDTH-1:0] req_index,
    input  logic [31:0]           req_raddr,
    input  logic [31:0]           req_waddr,
    input  logic [DATA_WIDTH-1:0] req_wline,
    output logic                  mem_ar_valid,
    input  logic                  mem_ar_ready,
    output logic [31:0]           mem_ar_addr,
    input  logic                  mem_r_valid,
    output logic                  mem_r_ready,
    input  logic [BEAT_WIDTH-1:0] mem_r_data,
    input  logic                  mem_r_last,
    output logic                  mem_aw_valid,
    input  logic                  mem_aw_ready,
    output logic [31:0]           mem_aw_addr,
    output logic                  mem_w_valid,
    input  logic                  mem_w_ready,
    output logic [BEAT_WIDTH-1:0] mem_w_data,
    output logic                  mem_w_last,
    input  logic                  mem_b_valid,
    output logic                  mem_b_ready,
    output logic                  dm_we,
    output logic [ADDR_WIDTH-1:0] dm_windex,
    output logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  done,
    output logic                  err,
    output state_t                dbg_state
);
    localparam int CNT_W = $clog2(BEATS);

    // Handshake rule on every channel: a transfer happens on the clock edge where
    // valid and ready are both high; valid never drops and its address/data never
    // change until that edge. Our valids/readies are Moore flags of the next state.
    state_t                           state_q, state_d;
    logic                             req_ready_q, aw_valid_q, w_valid_q, b_ready_q;
    logic                             ar_valid_q, r_ready_q, dm_we_q, done_q;
    logic [CNT_W-1:0]                 wcnt_q;
    logic [ADDR_WIDTH-1:0]            index_q;
    logic [31:0]                      raddr_q, waddr_q;
    logic [BEATS-1:0][BEAT_WIDTH-1:0] wline_q;
    logic                             accept, aw_hs, w_hs, b_hs, ar_hs, push, line_full;
    logic [DATA_WIDTH-1:0]            line;

    assign accept = req_valid & req_ready_q;
    assign aw_hs  = aw_valid_q & mem_aw_ready;
    assign w_hs   = w_valid_q & mem_w_ready;
    assign b_hs   = b_ready_q & mem_b_valid;
    assign ar_hs  = ar_valid_q & mem_ar_ready;
    assign push   = r_ready_q & mem_r_valid;

    refill_beat_buf #(
        .BEAT_WIDTH(BEAT_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .push    (push),
        .data_in (mem_r_data),
        .line_out(line),
        .full    (line_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = req_wb ? ST_WB_ADDR : ST_RD_ADDR;
            ST_WB_ADDR: if (aw_hs) state_d = ST_WB_DATA;
            ST_WB_DATA: if (w_hs && wcnt_q == CNT_W'(BEATS - 1)) state_d = ST_WB_RESP;
            ST_WB_RESP: if (b_hs) state_d = ST_RD_ADDR;
            ST_RD_ADDR: if (ar_hs) state_d = ST_RD_DATA;
            ST_RD_DATA: if (line_full) state_d = ST_COMMIT;
            ST_COMMIT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            dm_we_q     <= 1'b0;
            done_q      <= 1'b0;
            wcnt_q      <= '0;
            index_q     <= '0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            wline_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == ST_IDLE);
            aw_valid_q  <= (state_d == ST_WB_ADDR);
            w_valid_q   <= (state_d == ST_WB_DATA);
            b_ready_q   <= (state_d == ST_WB_RESP);
            ar_valid_q  <= (state_d == ST_RD_ADDR);
            r_ready_q   <= (state_d == ST_RD_DATA);
            dm_we_q     <= (state_d == ST_COMMIT);
            done_q      <= (state_d == ST_COMMIT);
            if (accept) begin
                index_q <= req_index;
                raddr_q <= line_align(req_raddr);
                waddr_q <= line_align(req_waddr);
                wline_q <= req_wline;
                wcnt_q  <= '0;
            end else if (w_hs) begin
                wcnt_q  <= wcnt_q + CNT_W'(1);
            end
        end
    end

`ifdef CACHE_REFILL_ERR_CHECK_EN
    logic err_q;

    // r_last must coincide exactly with the beat that completes the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (push && (mem_r_last != line_full)) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    logic r_last_unused;
    assign r_last_unused = mem_r_last;
    assign err           = 1'b0;
`endif

    assign req_ready    = req_ready_q;
    assign mem_aw_valid = aw_valid_q;
    assign mem_aw_addr  = waddr_q;
    assign mem_w_valid  = w_valid_q;
    assign mem_w_data   = wline_q[wcnt_q];
    assign mem_w_last   = w_valid_q && (wcnt_q == CNT_W'(BEATS - 1));
    assign mem_b_ready  = b_ready_q;
    assign mem_ar_valid = ar_valid_q;
    assign mem_ar_addr  = raddr_q;
    assign mem_r_ready  = r_ready_q;
    assign dm_we        = dm_we_q;
    assign dm_windex    = index_q;
    assign dm_wdata     = line;
    assign done         = done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_cache_refill_unit.sv
// Self-checking bench for cache_refill_unit: vector table, directed corner
// sequences and randomized transfers against a line-level reference model.
module tb_cache_refill_unit;
    import cache_pkg::*;

    localparam int DW = 128;
    localparam int BW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_wb;
    logic [AW-1:0] req_index;
    logic [31:0]   req_raddr, req_waddr;
    logic [DW-1:0] req_wline;
    logic          mem_ar_valid, mem_ar_ready;
    logic [31:0]   mem_ar_addr;
    logic          mem_r_valid, mem_r_ready, mem_r_last;
    logic [BW-1:0] mem_r_data;
    logic          mem_aw_valid, mem_aw_ready;
    logic [31:0]   mem_aw_addr;
    logic          mem_w_valid, mem_w_ready, mem_w_last;
    logic [BW-1:0] mem_w_data;
    logic          mem_b_valid, mem_b_ready;
    logic          dm_we, done, err;
    logic [AW-1:0] dm_windex;
    logic [DW-1:0] dm_wdata;
    state_t        dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    cache_refill_unit #(
        .DATA_WIDTH(DW),
        .BEAT_WIDTH(BW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wb      (req_wb),
        .req_index   (req_index),
        .req_raddr   (req_raddr),
        .req_waddr   (req_waddr),
        .req_wline   (req_wline),
        .mem_ar_valid(mem_ar_valid),
        .mem_ar_ready(mem_ar_ready),
        .mem_ar_addr (mem_ar_addr),
        .mem_r_valid (mem_r_valid),
        .mem_r_ready (mem_r_ready),
        .mem_r_data  (mem_r_data),
        .mem_r_last  (mem_r_last),
        .mem_aw_valid(mem_aw_valid),
        .mem_aw_ready(mem_aw_ready),
        .mem_aw_addr (mem_aw_addr),
        .mem_w_valid (mem_w_valid),
        .mem_w_ready (mem_w_ready),
        .mem_w_data  (mem_w_data),
        .mem_w_last  (mem_w_last),
        .mem_b_valid (mem_b_valid),
        .mem_b_ready (mem_b_ready),
        .dm_we       (dm_we),
        .dm_windex   (dm_windex),
        .dm_wdata    (dm_wdata),
        .done        (done),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks    = 0;
    int            n_fail      = 0;
    int            cyc         = 0;
    int            we_pulses   = 0;
    int            done_pulses = 0;
    int            exp_commits = 0;
    logic          exp_err     = 1'b0;
    logic [DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (dm_we === 1'b1) we_pulses++;
        if (done === 1'b1) done_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {127'b0, act}, {127'b0, exp});
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, {96'b0, act}, {96'b0, exp});
    endtask

    // ---------------- driver ----------------
    // mode 0: zero-wait bus; 1: random stalls; 2: ar_ready low 3 cycles + r_valid every other cycle.
    task automatic run_xfer(input logic wb, input logic [31:0] raddr, input logic [31:0] waddr,
                            input logic [DW-1:0] wline, input logic [AW-1:0] idx,
                            input logic [DW-1:0] beats, input logic [31:0] exp_ar,
                            input logic [DW-1:0] exp_line, input int mode, input int last_pos,
                            input bit keep_valid, input int exp_lat);
        int   t0, s, d, g;
        logic rdy, v;
        exp_q.push_back(exp_line);
        chk1("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_wb    = wb;
        req_raddr = raddr;
        req_waddr = waddr;
        req_wline = wline;
        req_index = idx;
        t0        = cyc;
        tick();
        if (!keep_valid) req_valid = 1'b0;
        if (wb) begin
            g = 0;
            do begin
                chk1("aw_valid", mem_aw_valid, 1'b1);
                chk32("aw_addr", mem_aw_addr, waddr & 32'hFFFF_FFF0);
                chk1("ar_before_wb", mem_ar_valid, 1'b0);
                rdy = (mode == 1 && g < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
                mem_aw_ready = rdy;
                tick();
                g++;
            end while (!rdy);
            mem_aw_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                g = 0;
                do begin
                    chk1("w_valid", mem_w_valid, 1'b1);
                    chk32("w_data", mem_w_data, wline[32*k +: 32]);
                    chk1("w_last", mem_w_last, k == 3);
                    chk1("we_during_wb", dm_we, 1'b0);
                    rdy = (mode == 1 && g < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
                    mem_w_ready = rdy;
                    tick();
                    g++;
                end while (!rdy);
            end
            mem_w_ready = 1'b0;
            d = (mode == 1) ? int'($urandom_range(0, 2)) : 0;
            for (int i = 0; i < d; i++) begin
                chk1("b_ready", mem_b_ready, 1'b1);
                chk1("ar_before_b", mem_ar_valid, 1'b0);
                tick();
            end
            chk1("b_ready", mem_b_ready, 1'b1);
            chk1("ar_before_b", mem_ar_valid, 1'b0);
            mem_b_valid = 1'b1;
            tick();
            mem_b_valid = 1'b0;
        end
        s = (mode == 2) ? 3 : (mode == 1) ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i <= s; i++) begin
            chk1("ar_valid", mem_ar_valid, 1'b1);
            chk32("ar_addr", mem_ar_addr, exp_ar);
            mem_ar_ready = (i == s);
            tick();
        end
        mem_ar_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            g = 0;
            do begin
                chk1("r_ready", mem_r_ready, 1'b1);
                chk1("early_we", dm_we, 1'b0);
                chk1("req_ready_busy", req_ready, 1'b0);
                v = (mode == 2) ? (g % 2 == 1) :
                    (mode == 1 && g < 2) ? 1'($urandom_range(0, 1)) : 1'b1;
                mem_r_valid = v;
                mem_r_data  = v ? beats[32*k +: 32] : $urandom;
                mem_r_last  = v && (k == last_pos);
                tick();
                g++;
            end while (!v);
        end
        mem_r_valid = 1'b0;
        mem_r_last  = 1'b0;
`ifdef CACHE_REFILL_ERR_CHECK_EN
        exp_err = exp_err | (last_pos != 3);
`endif
        exp_commits++;
        chk1("commit_we", dm_we, 1'b1);
        chk1("commit_done", done, 1'b1);
        chk("commit_index", {120'b0, dm_windex}, {120'b0, idx});
        chk("commit_line", dm_wdata, exp_q.pop_front());
        chk1("err", err, exp_err);
        if (exp_lat >= 0) chk32("commit_latency", 32'(cyc - t0), 32'(exp_lat));
        tick();
        chk1("we_after_commit", dm_we, 1'b0);
        chk1("done_after_commit", done, 1'b0);
        chk1("req_ready_after", req_ready, 1'b1);
        chk1("err_sticky", err, exp_err);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0]   raddr;
        logic [AW-1:0] idx;
        logic [31:0]   b [4];
        logic [31:0]   exp_ar;
        logic [DW-1:0] exp_line;
    } vec_t;

    vec_t          vecs [4];
    logic [DW-1:0] beats_v, wline_v, line_m;
    logic [31:0]   ra, wa, bq[$];
    logic [AW-1:0] idx_v;
    logic          wb_v;

    initial begin
        vecs[0] = '{32'h0000_1234, 8'h5A, '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
                    32'h0000_1230, 128'h44444444_33333333_22222222_11111111};
        vecs[1] = '{32'hFFFF_FFFF, 8'hFF, '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h00000000},
                    32'hFFFF_FFF0, 128'h00000000_89ABCDEF_01234567_DEADBEEF};
        vecs[2] = '{32'h0000_0010, 8'h00, '{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF},
                    32'h0000_0010, 128'hFFFFFFFF_00000000_FFFFFFFF_00000000};
        vecs[3] = '{32'h8000_000F, 8'h01, '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hC3C3C3C3, 32'h3C3C3C3C},
                    32'h8000_0000, 128'h3C3C3C3C_C3C3C3C3_5A5A5A5A_A5A5A5A5};

        reset = 1'b1;
        req_valid = 1'b1;  // must be ignored while reset is high
        req_wb = 1'b1; req_index = 8'hEE; req_raddr = 32'hCAFE_0000; req_waddr = 32'hBEEF_0000;
        req_wline = '1;
        mem_ar_ready = 1'b0; mem_r_valid = 1'b0; mem_r_data = '0; mem_r_last = 1'b0;
        mem_aw_ready = 1'b0; mem_w_ready = 1'b0; mem_b_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        req_valid = 1'b0;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_ar_valid", mem_ar_valid, 1'b0);
        chk1("rst_aw_valid", mem_aw_valid, 1'b0);
        chk1("rst_w_valid", mem_w_valid, 1'b0);
        chk1("rst_r_ready", mem_r_ready, 1'b0);
        chk1("rst_b_ready", mem_b_ready, 1'b0);
        chk1("rst_dm_we", dm_we, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_ar_addr", mem_ar_addr, 32'h0);
        chk32("rst_aw_addr", mem_aw_addr, 32'h0);
        tick();
        chk1("no_accept_in_reset", mem_aw_valid | mem_ar_valid, 1'b0);

        // Table: refill-only, zero-wait, latency T+6.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) beats_v[32*j +: 32] = vecs[i].b[j];
            run_xfer(1'b0, vecs[i].raddr, 32'h0, '0, vecs[i].idx, beats_v,
                     vecs[i].exp_ar, vecs[i].exp_line, 0, 3, 1'b0, 6);
        end

        // Writeback + refill, zero-wait, commit at T+12.
        wline_v = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        beats_v = 128'h0F0F0F0F_E1E1E1E1_D2D2D2D2_C3C3C3C3;
        run_xfer(1'b1, 32'h0000_9004, 32'h0000_8040, wline_v, 8'h21, beats_v,
                 32'h0000_9000, 128'h0F0F0F0F_E1E1E1E1_D2D2D2D2_C3C3C3C3, 0, 3, 1'b0, 12);

        // Stalled address channel and gapped read data.
        beats_v = 128'h76543210_FEDCBA98_13579BDF_2468ACE0;
        run_xfer(1'b0, 32'h0000_3ABC, 32'h0, '0, 8'h7E, beats_v,
                 32'h0000_3AB0, 128'h76543210_FEDCBA98_13579BDF_2468ACE0, 2, 3, 1'b0, -1);

        // Reset after two read beats: partial line discarded, nothing written.
        req_valid = 1'b1; req_wb = 1'b0; req_raddr = 32'h0000_2000; req_index = 8'h33;
        tick();
        req_valid = 1'b0;
        chk1("mid_ar_valid", mem_ar_valid, 1'b1);
        mem_ar_ready = 1'b1;
        tick();
        mem_ar_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk1("mid_r_ready", mem_r_ready, 1'b1);
            mem_r_valid = 1'b1;
            mem_r_data  = 32'h5EA1_0000 + 32'(k);
            tick();
        end
        mem_r_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_err = 1'b0;
        chk1("mid_rst_req_ready", req_ready, 1'b1);
        chk1("mid_rst_r_ready", mem_r_ready, 1'b0);
        chk1("mid_rst_dm_we", dm_we, 1'b0);
        chk1("mid_rst_done", done, 1'b0);
        tick();
        chk1("mid_rst_idle_we", dm_we, 1'b0);
        beats_v = 128'hF4F4F4F4_F3F3F3F3_F2F2F2F2_F1F1F1F1;
        run_xfer(1'b0, 32'h0000_2000, 32'h0, '0, 8'h34, beats_v,
                 32'h0000_2000, 128'hF4F4F4F4_F3F3F3F3_F2F2F2F2_F1F1F1F1, 0, 3, 1'b0, 6);

        // Back-to-back with req_valid held: second accept lands at T+7.
        beats_v = 128'h0000000D_0000000C_0000000B_0000000A;
        run_xfer(1'b0, 32'h0000_4440, 32'h0, '0, 8'h40, beats_v,
                 32'h0000_4440, 128'h0000000D_0000000C_0000000B_0000000A, 0, 3, 1'b1, 6);
        beats_v = 128'h1000000D_1000000C_1000000B_1000000A;
        run_xfer(1'b0, 32'h0000_5550, 32'h0, '0, 8'h41, beats_v,
                 32'h0000_5550, 128'h1000000D_1000000C_1000000B_1000000A, 0, 3, 1'b0, 6);

        // Randomized transfers against the line-level model.
        for (int i = 0; i < 20; i++) begin
            wb_v    = 1'($urandom_range(0, 1));
            ra      = $urandom;
            wa      = $urandom;
            idx_v   = 8'($urandom);
            wline_v = {$urandom, $urandom, $urandom, $urandom};
            bq.delete();
            for (int j = 0; j < 4; j++) bq.push_back($urandom);
            line_m  = {bq[3], bq[2], bq[1], bq[0]};
            beats_v = '0;
            for (int j = 0; j < 4; j++) beats_v[32*j +: 32] = bq[j];
            run_xfer(wb_v, ra, wa, wline_v, idx_v, beats_v, ra - (ra % 32'd16),
                     line_m, 1, 3, 1'b0, -1);
        end

        // r_last on beat 1: err only with the check enabled, sticky past commit.
        beats_v = 128'hE0000004_E0000003_E0000002_E0000001;
        run_xfer(1'b0, 32'h0000_6000, 32'h0, '0, 8'h60, beats_v,
                 32'h0000_6000, 128'hE0000004_E0000003_E0000002_E0000001, 0, 1, 1'b0, 6);
        beats_v = 128'hB0000004_B0000003_B0000002_B0000001;
        run_xfer(1'b1, 32'h0000_7000, 32'h0000_7100, {4{32'h7777_7777}}, 8'h70, beats_v,
                 32'h0000_7000, 128'hB0000004_B0000003_B0000002_B0000001, 0, 3, 1'b0, 12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_err = 1'b0;
        chk1("err_cleared_by_reset", err, 1'b0);

        tick();
        chk32("dm_we_pulse_count", 32'(we_pulses), 32'(exp_commits));
        chk32("done_pulse_count", 32'(done_pulses), 32'(exp_commits));
        chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_refill_unit.md
# cache_refill_unit

Memory-side line-transfer engine for the data cache. On a miss it writes back a dirty victim line as 4 × 32-bit beats, then fetches the replacement line as 4 × 32-bit beats. It assembles the fetched beats into one 128-bit line and commits that line through the data-array write port (we / windex / wdata). It sits between the cache controller FSM (upstream) and the data array plus main-memory bus (downstream).

## Interface
- DATA_WIDTH, 128, line width; must equal data-array width
- BEAT_WIDTH, 32, memory bus beat width; BEATS = DATA_WIDTH/BEAT_WIDTH = 4
- ADDR_WIDTH, 8, data-array index width
- clk  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- req_valid  in  1  controller requests a transfer
- req_ready  out  1  high iff state IDLE
- req_wb  in  1  1 = write back victim before refill
- req_index  in  ADDR_WIDTH  data-array index to fill
- req_raddr  in  32  refill byte address
- req_waddr  in  32  victim byte address
- req_wline  in  DATA_WIDTH  victim line data
- mem_ar_valid / mem_ar_ready  out/in  1  read-address handshake; mem_ar_addr  out  32
- mem_r_valid / mem_r_ready  in/out  1  read-data handshake; mem_r_data  in  BEAT_WIDTH; mem_r_last  in  1
- mem_aw_valid / mem_aw_ready  out/in  1  write-address handshake; mem_aw_addr  out  32
- mem_w_valid / mem_w_ready  out/in  1  write-data handshake; mem_w_data  out  BEAT_WIDTH; mem_w_last  out  1
- mem_b_valid / mem_b_ready  in/out  1  write-response handshake
- dm_we  out  1  data-array write enable; dm_windex  out  ADDR_WIDTH; dm_wdata  out  DATA_WIDTH
- done  out  1  one-cycle pulse when the line is committed
- err  out  1  sticky beat-count error (see Configuration)

## Operation
- States: IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, COMMIT.
- Request acceptance:
  - Accepted on req_valid & req_ready.
  - All req_* inputs are latched on acceptance.
  - Next state: WB_ADDR if req_wb, else RD_ADDR.
- Bus addresses are line-aligned: the low log2(DATA_WIDTH/8) = 4 bits are forced to 0.
- WB_ADDR: mem_aw_valid high until mem_aw_ready, then WB_DATA.
- WB_DATA:
  - Beat k drives latched victim bits [32k+31:32k], lowest first.
  - mem_w_valid is held on each beat until mem_w_ready.
  - mem_w_last is high on beat 3.
  - After the beat-3 handshake, go to WB_RESP.
- WB_RESP: mem_b_ready high; on mem_b_valid go to RD_ADDR.
- RD_ADDR: mem_ar_valid high until mem_ar_ready, then RD_DATA.
- RD_DATA:
  - mem_r_ready is high.
  - Each handshake stores mem_r_data into buffer slot beat_cnt and increments the 2-bit beat_cnt.
  - On the 4th beat go to COMMIT.
- COMMIT:
  - dm_we = 1, dm_windex = latched index, dm_wdata = assembled line, done = 1, all for exactly one cycle.
  - Next state IDLE.
- Outside COMMIT: dm_we = 0 and done = 0. dm_wdata/dm_windex hold their last values and are don't-care.
- Valid signals never drop before their handshake completes. Address/data outputs stay stable while valid is high.
- Reset at any point:
  - Return to IDLE and clear beat_cnt, err and all valid/ready/we/done outputs.
  - A partial line is discarded and the data array is never written.

## Timing
- Reset values:
  - req_ready = 1 once in IDLE; requests presented while reset is high are ignored.
  - Every other output = 0.
- Refill-only minimum latency: accept at T → ar_valid T+1 → beats T+2..T+5 → COMMIT (dm_we, done) at T+6 → req_ready at T+7.
- With writeback and zero-wait bus: accept at T → aw T+1 → w beats T+2..T+5 → b T+6 → ar T+7 → COMMIT at T+12.
- Bus stalls add one cycle each. There is no timeout.
- One transfer at a time; no request queuing.

## Configuration
- CACHE_REFILL_ERR_CHECK_EN defined:
  - err is set if mem_r_last is high on beats 0–2, or low on beat 3.
  - err is sticky until reset.
  - The line is still committed after 4 beats.
- Undefined: mem_r_last is ignored and err is tied to 0.

## Structure
- Shared package cache_pkg holds:
  - the state enum;
  - BEATS;
  - OFFSET_BITS = log2(DATA_WIDTH/8);
  - the line-align function.
- One sub-module: refill_beat_buf. It is the 4-slot assembly register plus beat_cnt, with ports clear / push / data_in / line_out / full.

## Test plan
- Refill only, zero-wait bus: req_raddr 0x0000_1234, index 0x5A, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 → ar_addr 0x0000_1230; at T+6, dm_we = 1, dm_windex 0x5A, dm_wdata 0x44444444_33333333_22222222_11111111, done = 1.
- Writeback + refill: victim 0xDDDD…_AAAA… at waddr 0x0000_8040 → w beats emitted low-to-high with w_last on beat 3; ar_valid only after b_valid; COMMIT at T+12.
- Stalls: mem_ar_ready low 3 cycles, mem_r_valid gapped every other cycle → ar_addr stable throughout; line correct; no dm_we before the 4th beat.
- Reset asserted after 2 read beats → next cycle IDLE, req_ready = 1, dm_we never pulses; a new request then fills a fresh line with no stale beats.
- Back-to-back: req_valid held high → second request accepted at T+7, not earlier.
- With CACHE_REFILL_ERR_CHECK_EN: r_last on beat 1 → err = 1 and stays set after COMMIT; without the macro, err stays 0.
